// File: rtl/seq_multiplier_32.sv
// Iterative unsigned 32x32->64 shift-and-add multiplier built around one
// CLA_32bit; 32 RUN steps behind a start/busy/done handshake.

module CLA_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g    = A & B;
  assign p    = A ^ B;
  assign c[0] = Cin;

  // Full lookahead inside each 4-bit group; group carries ripple between groups.
  for (genvar k = 0; k < 8; k++) begin : grp
    localparam int base = 4 * k;
    assign c[base+1] = g[base] | (p[base] & c[base]);
    assign c[base+2] = g[base+1] | (p[base+1] & g[base])
                     | (p[base+1] & p[base] & c[base]);
    assign c[base+3] = g[base+2] | (p[base+2] & g[base+1])
                     | (p[base+2] & p[base+1] & g[base])
                     | (p[base+2] & p[base+1] & p[base] & c[base]);
    assign c[base+4] = g[base+3] | (p[base+3] & g[base+2])
                     | (p[base+3] & p[base+2] & g[base+1])
                     | (p[base+3] & p[base+2] & p[base+1] & g[base])
                     | (p[base+3] & p[base+2] & p[base+1] & p[base] & c[base]);
  end

  assign Sum  = p ^ c[31:0];
  assign Cout = c[32];
endmodule

module seq_multiplier_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  count;
  logic [31:0] sum;
  logic        cout;

  CLA_32bit u_cla (
    .A   (hi),
    .B   (mcand),
    .Cin (1'b0),
    .Sum (sum),
    .Cout(cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? RUN : IDLE;
      RUN:     next_state = (count == 5'd31) ? DONE : RUN;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The carry-out lands in hi[31], so the 65-bit sum never loses a bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      count <= 5'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= a;
            hi    <= 32'd0;
            lo    <= b;
            count <= 5'd0;
          end
        end
        RUN: begin
          if (lo[0]) begin
            {hi, lo} <= {cout, sum, lo[31:1]};
          end else begin
            {hi, lo} <= {1'b0, hi, lo[31:1]};
          end
          count <= count + 5'd1;
        end
        default: begin
          count <= 5'd0;
        end
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = {hi, lo};
endmodule
